// File: rtl/count_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_mon_pkg
//  Description : Shared types and default widths for the counter wrap
//                monitor: FSM state encoding and the per-cycle delta class.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_mon_pkg;

    // Default width of the observed counter value.
    localparam int c_DEFAULT_CNT_W = 4;

    // Default width of the signed net-revolution count.
    localparam int c_DEFAULT_REV_W = 8;

    // Monitor FSM states. S_INIT re-captures the counter after any reset or
    // clear so the first observed value is never mistaken for a step.
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } mon_state_t;

    // Classification of (y - prev_y) mod 2^CNT_W.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        JUMP = 2'd3
    } delta_cls_t;

endpackage
`default_nettype wire

// File: rtl/count_wrap_monitor_acc.sv
`default_nettype none
// ============================================================================
//  Module      : sat_updown_acc
//  Description : Signed two's-complement +1/-1 accumulator that saturates at
//                the most positive and most negative representable values.
//                Synchronous reset and synchronous clear both return it to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_updown_acc
    import count_mon_pkg::*;
#(
    parameter int W = c_DEFAULT_REV_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic                dec,
    output logic signed [W-1:0] acc
);

    // Saturation limits: 0111..1 and 1000..0.
    localparam logic signed [W-1:0] c_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic        [W-1:0] c_ONE = W'(1);

    logic signed [W-1:0] r_acc;

    // Accumulate single steps, holding at either limit; simultaneous inc and
    // dec cancel out and leave the value unchanged.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= '0;
        end else if (inc && !dec && (r_acc != c_MAX)) begin
            r_acc <= r_acc + c_ONE;
        end else if (dec && !inc && (r_acc != c_MIN)) begin
            r_acc <= r_acc - c_ONE;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_wrap_monitor
//  Description : Observer for an up/down counter. Classifies every observed
//                transition (hold / up / down / jump), pulses ovf on a
//                max->0 up-wrap and udf on a 0->max down-wrap, keeps a
//                saturating signed net-revolution count, and raises sticky
//                jump and direction error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W = c_DEFAULT_CNT_W,
    parameter int REV_W = c_DEFAULT_REV_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic        [CNT_W-1:0] y,
    input  logic                    mode,
    input  logic                    clr,
    output logic                    ovf,
    output logic                    udf,
    output logic signed [REV_W-1:0] rev_count,
    output logic                    jump_err,
    output logic                    dir_err,
    output logic                    tracking
);

    localparam logic [CNT_W-1:0] c_ZERO_Y = '0;
    localparam logic [CNT_W-1:0] c_ONE_Y  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX_Y  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mon_state_t       r_state;
    mon_state_t       w_next_state;
    logic [CNT_W-1:0] r_prev_y;
    logic             r_mode_q;

    logic             r_ovf;
    logic             r_udf;
    logic             r_jump_err;
    logic             r_dir_err;

    // ------------------------------------------------------------------
    // Combinational classification and event decode
    // ------------------------------------------------------------------
    logic             w_clear;
    logic [CNT_W-1:0] w_delta;
    delta_cls_t       w_cls;
    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic             w_set_jump;
    logic             w_set_dir;

    // rst and clr reset exactly the same monitor state.
    assign w_clear = rst | clr;

    // Modular difference wraps naturally at CNT_W bits.
    assign w_delta = y - r_prev_y;

    // The only transitions that count as revolutions.
    assign w_wrap_up = (r_prev_y == c_MAX_Y) && (y == c_ZERO_Y);
    assign w_wrap_dn = (r_prev_y == c_ZERO_Y) && (y == c_MAX_Y);

    // Map the delta to a step class. With a 1-bit counter +1 and -1 are the
    // same value, so the direction the counter was told to use decides.
    always_comb begin
        w_cls = JUMP;
        if (w_delta == c_ZERO_Y) begin
            w_cls = HOLD;
        end else if ((w_delta == c_ONE_Y) && (w_delta == c_MAX_Y)) begin
            w_cls = r_mode_q ? UP : DOWN;
        end else if (w_delta == c_ONE_Y) begin
            w_cls = UP;
        end else if (w_delta == c_MAX_Y) begin
            w_cls = DOWN;
        end
    end

    // Next-state and event decode; only S_TRACK produces events.
    always_comb begin
        w_next_state = r_state;
        w_set_ovf    = 1'b0;
        w_set_udf    = 1'b0;
        w_set_jump   = 1'b0;
        w_set_dir    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_next_state = S_TRACK;
            end
            S_TRACK: begin
                case (w_cls)
                    UP: begin
                        w_set_ovf = w_wrap_up;
                        w_set_dir = ~r_mode_q;
                    end
                    DOWN: begin
                        w_set_udf = w_wrap_dn;
                        w_set_dir = r_mode_q;
                    end
                    JUMP: begin
                        w_set_jump   = 1'b1;
                        w_next_state = S_FAULT;
                    end
                    default: begin
                        // HOLD is legal: the counter may be parked in reset.
                    end
                endcase
            end
            S_FAULT: begin
                // Only rst or clr leaves the fault state.
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM register plus the one-cycle history of the counter value and mode.
    // History keeps updating in every state so recovery starts from fresh data.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state  <= S_INIT;
            r_prev_y <= '0;
            r_mode_q <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_prev_y <= y;
            r_mode_q <= mode;
        end
    end

    // Registered single-cycle wrap pulses and sticky error flags.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_jump_err <= 1'b0;
            r_dir_err  <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf;
            r_udf <= w_set_udf;
            if (w_set_jump) begin
                r_jump_err <= 1'b1;
            end
            if (w_set_dir) begin
                r_dir_err <= 1'b1;
            end
        end
    end

    // Net revolutions follow the same registered wrap events as ovf/udf.
    sat_updown_acc #(
        .W   (REV_W)
    ) u_rev_acc (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_set_ovf),
        .dec (w_set_udf),
        .acc (rev_count)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ovf      = r_ovf;
    assign udf      = r_udf;
    assign jump_err = r_jump_err;
    assign dir_err  = r_dir_err;
    assign tracking = (r_state == S_TRACK);

endmodule
`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_wrap_monitor
//  Description : Self-checking bench for count_wrap_monitor. A behavioural
//                4-bit up/down counter drives y (or y is forced directly),
//                and an arithmetic reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_wrap_monitor;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic        [3:0] y = 4'd0;
    logic              mode = 1'b1;
    logic              clr = 1'b0;
    logic              ovf;
    logic              udf;
    logic signed [7:0] rev_count;
    logic              jump_err;
    logic              dir_err;
    logic              tracking;

    // When set, y behaves as the real counter; otherwise y is driven directly.
    bit use_cnt = 1'b1;

    int total = 0;
    int bad   = 0;

    count_wrap_monitor #(
        .CNT_W     (4),
        .REV_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .mode      (mode),
        .clr       (clr),
        .ovf       (ovf),
        .udf       (udf),
        .rev_count (rev_count),
        .jump_err  (jump_err),
        .dir_err   (dir_err),
        .tracking  (tracking)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase 0 = waiting to capture, 1 = tracking,
    // 2 = faulted. Expectations come from modular arithmetic on y.
    // ------------------------------------------------------------------
    bit m_valid = 1'b0;
    int m_phase = 0;
    int m_prev  = 0;
    bit m_modeq = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;
    int m_rev   = 0;
    bit m_jump  = 1'b0;
    bit m_dir   = 1'b0;
    int m_d;

    always @(posedge clk) begin
        if (rst) m_valid = 1'b1;
        if (rst || clr) begin
            m_phase = 0; m_prev = 0; m_modeq = 1'b0;
            m_ovf = 1'b0; m_udf = 1'b0; m_rev = 0;
            m_jump = 1'b0; m_dir = 1'b0;
        end else begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
            if (m_phase == 1) begin
                m_d = (int'(y) - m_prev + 16) % 16;
                if (m_d == 1) begin
                    if (m_prev == 15) begin
                        m_ovf = 1'b1;
                        if (m_rev < 127) m_rev = m_rev + 1;
                    end
                    if (!m_modeq) m_dir = 1'b1;
                end else if (m_d == 15) begin
                    if (m_prev == 0) begin
                        m_udf = 1'b1;
                        if (m_rev > -128) m_rev = m_rev - 1;
                    end
                    if (m_modeq) m_dir = 1'b1;
                end else if (m_d != 0) begin
                    m_jump  = 1'b1;
                    m_phase = 2;
                end
            end else if (m_phase == 0) begin
                m_phase = 1;
            end
            m_prev  = int'(y);
            m_modeq = mode;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ovf",       int'(ovf),       int'(m_ovf));
            chk("udf",       int'(udf),       int'(m_udf));
            chk("rev_count", int'(rev_count), m_rev);
            chk("jump_err",  int'(jump_err),  int'(m_jump));
            chk("dir_err",   int'(dir_err),   int'(m_dir));
            chk("tracking",  int'(tracking),  (m_phase == 1) ? 1 : 0);
        end
    end

    // One clock; the counter model updates y just after the edge.
    task automatic tick(input bit hold);
        @(posedge clk);
        #1;
        if (use_cnt) begin
            if (rst)        y = 4'd0;
            else if (!hold) y = mode ? y + 4'd1 : y - 4'd1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic run_pulses(input bit up, input int n, input int budget, output int got);
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            tick(1'b0);
            if (up ? ovf : udf) got++;
        end
    endtask

    task automatic run_until_y(input int val, input int budget, output bit found);
        found = (int'(y) == val);
        for (int i = 0; i < budget && !found; i++) begin
            tick(1'b0);
            if (int'(y) == val) found = 1'b1;
        end
    endtask

    initial begin
        int r;
        int got;
        bit found;

        // Reset state and free-running up count.
        mode = 1'b1;
        rst  = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_rev", int'(rev_count), 0);
        chk("rst_tracking", int'(tracking), 0);
        chk("rst_jump", int'(jump_err), 0);
        rst = 1'b0;
        tick(1'b0);
        chk("track_after_release", int'(tracking), 1);
        run_pulses(1'b1, 3, 100, got);
        chk("up_wraps_seen", got, 3);
        chk("ovf_latency_y", int'(y), 1);
        chk("lit_rev3", int'(rev_count), 3);
        chk("model_rev3", m_rev, 3);
        tick(1'b0);
        chk("ovf_single_cycle", int'(ovf), 0);

        // Down count from reset: first step 0->15, udf one cycle later.
        mode = 1'b0;
        do_reset();
        tick(1'b0);
        chk("down_first_y", int'(y), 15);
        tick(1'b0);
        chk("lit_udf", int'(udf), 1);
        chk("lit_rev_m1", int'(rev_count), -1);
        chk("lit_dir0", int'(dir_err), 0);
        tick(1'b0);
        chk("udf_single_cycle", int'(udf), 0);

        // Positive saturation, then negative saturation.
        mode = 1'b1;
        do_reset();
        run_pulses(1'b1, 129, 129 * 16 + 40, got);
        chk("sat_hi_pulses", got, 129);
        chk("lit_sat_hi", int'(rev_count), 127);
        mode = 1'b0;
        do_reset();
        run_pulses(1'b0, 130, 130 * 16 + 40, got);
        chk("sat_lo_pulses", got, 130);
        chk("lit_sat_lo", int'(rev_count), -128);
        chk("model_sat_lo", m_rev, -128);

        // Jump into fault, ignored wrap, then clear.
        mode = 1'b1;
        do_reset();
        run_pulses(1'b1, 1, 40, got);
        chk("pre_jump_wrap", got, 1);
        run_until_y(5, 20, found);
        chk("reach_y5", int'(found), 1);
        use_cnt = 1'b0;
        y = 4'd9;
        tick(1'b0);
        chk("lit_jump", int'(jump_err), 1);
        chk("lit_fault_tracking", int'(tracking), 0);
        y = 4'd15;
        tick(1'b0);
        y = 4'd0;
        tick(1'b0);
        chk("fault_no_ovf", int'(ovf), 0);
        chk("fault_rev_frozen", int'(rev_count), 1);
        clr = 1'b1;
        tick(1'b0);
        clr = 1'b0;
        chk("clr_jump", int'(jump_err), 0);
        chk("clr_rev", int'(rev_count), 0);
        chk("clr_tracking_init", int'(tracking), 0);
        tick(1'b0);
        chk("clr_tracking", int'(tracking), 1);

        // Direction error: 3->4 while the mode was down.
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        y    = 4'd3;
        mode = 1'b0;
        rst  = 1'b0;
        tick(1'b0);
        y = 4'd4;
        tick(1'b0);
        chk("lit_dir", int'(dir_err), 1);
        chk("dir_tracking", int'(tracking), 1);
        mode    = 1'b1;
        use_cnt = 1'b1;
        run_pulses(1'b1, 1, 40, got);
        chk("dir_wrap_counted", got, 1);
        chk("dir_rev", int'(rev_count), 1);
        chk("dir_sticky", int'(dir_err), 1);

        // Shared reset mid-run.
        do_reset();
        run_until_y(12, 30, found);
        chk("reach_y12", int'(found), 1);
        rst = 1'b1;
        tick(1'b0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_udf", int'(udf), 0);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("midrst_jump", int'(jump_err), 0);
        chk("midrst_rev", int'(rev_count), 0);

        // Randomised traffic: resets, clears, mode flips, holds and forced y.
        for (int i = 0; i < 2000; i++) begin
            r    = int'($urandom_range(0, 999));
            rst  = (r < 15);
            clr  = (r < 5) || (r >= 15 && r < 35);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            if ($urandom_range(0, 39) == 0) y = 4'($urandom);
            tick($urandom_range(0, 7) == 0);
        end
        rst = 1'b0;
        clr = 1'b0;
        tick(1'b0);
        tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Downstream observer of the 4-bit up/down counter. Samples the counter value `y` and `mode` every clock and classifies each transition as hold, up-step or down-step.
- Emits single-cycle overflow (15->0) and underflow (0->15) pulses and keeps a signed, saturating net-revolution count.
- Flags illegal jumps and direction mismatches. Sits beside the counter in the same clock domain and feeds status logic/LEDs.

Parameters:
- CNT_W, 4: width of monitored counter value.
- REV_W, 8: width of signed net-revolution counter (two's complement).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high. Must be driven by the same rst as the counter.
- y  input  CNT_W  counter value, registered in counter.
- mode  input  1  counter direction (1=up, 0=down), same signal that drives the counter.
- clr  input  1  synchronous clear of rev_count, sticky flags and FSM (no effect on y).
- ovf  output  1  one-cycle pulse: wrap max->0 observed while going up.
- udf  output  1  one-cycle pulse: wrap 0->max observed while going down.
- rev_count  output  REV_W  signed net revolutions (+1 per ovf, -1 per udf), saturating.
- jump_err  output  1  sticky: delta not in {0,+1,-1}.
- dir_err  output  1  sticky: step direction disagrees with mode used for that step.
- tracking  output  1  high while FSM in S_TRACK.

Behaviour:
- Internal registers:
  - prev_y (CNT_W): y from last cycle.
  - mode_q: mode from last cycle, i.e. the mode the counter used to produce the current y.
- delta = (y - prev_y) mod 2^CNT_W. Classes:
  - 0 = hold.
  - 1 = up.
  - all-ones = down.
  - anything else = jump.
- FSM states S_INIT, S_TRACK, S_FAULT; encoding in package.
  - S_INIT: capture prev_y<=y, mode_q<=mode; no classification, no pulses. Goes to S_TRACK next cycle.
  - S_TRACK: classify each cycle.
    - up with prev_y=max and y=0: ovf=1; rev_count+1 unless already at +2^(REV_W-1)-1.
    - down with prev_y=0 and y=max: udf=1; rev_count-1 unless already at -2^(REV_W-1).
    - up with mode_q=0, or down with mode_q=1: dir_err<=1, stay S_TRACK. The ovf/udf pulse still fires.
    - hold: no flags. Legal because the counter may be held in reset.
    - jump: jump_err<=1, go to S_FAULT, no ovf/udf that cycle.
  - S_FAULT: ovf/udf forced 0, rev_count frozen, prev_y/mode_q keep updating. Exit only via clr or rst -> S_INIT.
- Latency: ovf/udf/flag updates are registered. They assert in the cycle after the wrapped y first appears on the port, and are high for exactly one cycle.
- rst (highest priority):
  - FSM=S_INIT.
  - ovf=udf=0, rev_count=0, jump_err=dir_err=0, tracking=0.
  - prev_y=0, mode_q=0.
- clr (below rst): same effect as rst on all monitor state. The cycle clr is high produces no pulse.
- Simultaneous rst/clr: rst wins; the outcome is identical.
- Counter reset mid-run via shared rst: both restart together, and no false jump is reported (S_INIT re-captures).
- Consecutive wraps (e.g. CNT_W=1) each produce a pulse; back-to-back pulses are allowed.

Decomposition:
- Package count_mon_pkg holds:
  - FSM state typedef (S_INIT=2'd0, S_TRACK=2'd1, S_FAULT=2'd2).
  - Delta-class enum (HOLD, UP, DOWN, JUMP).
  - Default CNT_W/REV_W constants.
- One natural sub-module: sat_updown_acc, a signed REV_W saturating ±1 accumulator with sync clear, used for rev_count.
- Classification stays combinational inside the top.

Test Plan:
- rst 2 cycles, mode=1, counter free-runs from 0 -> first ovf exactly one cycle after y=0 following y=15; after 3 wraps rev_count=3; no errors; tracking=1 from cycle 2 after rst release.
- mode=0 from reset -> y goes 0->15 on first step; udf pulses once one cycle later; rev_count=-1 (8'hFF); dir_err=0.
- Force rev_count to +127 via 127 up-wraps, run 2 more wraps -> ovf still pulses, rev_count stays 127; mirror case at -128 for udf.
- Drive y directly 5->9 in S_TRACK -> jump_err=1 next cycle, tracking=0. Then drive a valid 15->0 -> no ovf, rev_count unchanged. Then pulse clr -> all flags 0, rev_count=0, tracking=1 two cycles later.
- Drive y 3->4 with mode_q=0 -> dir_err=1 sticky, FSM stays S_TRACK, later wraps still counted.
- Assert rst mid-run with y=12 (counter goes to 0) -> no jump_err, rev_count=0, ovf/udf low during and after reset cycle.
